// File: rtl/mux4way_arbiter_pkg.sv
// Shared types and constants for the 4-way merge arbiter and its picker.
// Channel i occupies the slice starting at ch_off(i, width) of a packed bus.
package mux4way_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE, LOCKED} state_t;

  function automatic int ch_off(input logic [SEL_W-1:0] ch, input int width);
    return int'(ch) * width;
  endfunction
endpackage

// File: rtl/mux4way_arbiter_if.sv
// Four valid/ready source streams in, one tagged stream out.
// slave = arbiter side, master = sources plus downstream consumer.
interface mux4way_arbiter_if #(parameter int WIDTH = 16);
  import mux4way_pkg::*;

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_last;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/mux4way_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester after ptr wins,
// ptr itself has the lowest priority.
module rr_pick4
  import mux4way_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  // Walk from lowest to highest priority so the highest-priority hit lands last.
  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux4way_arbiter.sv
// Merges four source streams into one registered output stream with
// round-robin arbitration; a multi-beat packet keeps the grant until its last beat.
module mux4way_arbiter
  import mux4way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4way_arbiter_if.slave    bus
);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  lock_ch;

  logic [WIDTH-1:0]  out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_last;
  logic              out_valid;

  logic              load;
  logic              pick_valid;
  logic [SEL_W-1:0]  pick_idx;
  logic              gnt_ok;
  logic [SEL_W-1:0]  gidx;
  logic [NUM_CH-1:0] ready;
  logic              xfer;

  rr_pick4 u_pick (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign load   = ~out_valid | bus.out_ready;
  assign gnt_ok = (state == LOCKED) ? 1'b1 : pick_valid;
  assign gidx   = (state == LOCKED) ? lock_ch : pick_idx;

  // Held low during reset so no beat can be accepted and then dropped.
  always_comb begin
    ready = '0;
    if (rst_n && load && gnt_ok) ready[gidx] = 1'b1;
  end

  assign xfer = |(bus.in_valid & ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_ch   <= '0;
      ptr       <= SEL_W'(NUM_CH - 1);
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= bus.in_data[ch_off(gidx, WIDTH) +: WIDTH];
      out_sel   <= gidx;
      out_last  <= bus.in_last[gidx];
      out_valid <= 1'b1;
      ptr       <= gidx;
      case (state)
        IDLE: begin
          if (!bus.in_last[gidx]) begin
            state   <= LOCKED;
            lock_ch <= gidx;
          end
        end
        LOCKED: begin
          if (bus.in_last[gidx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data;
  assign bus.out_sel   = out_sel;
  assign bus.out_last  = out_last;
  assign bus.out_valid = out_valid;

endmodule

// File: doc/mux4way_arbiter.md
Name: mux4way_arbiter

Overview:
- Gathers four valid/ready source streams into one registered output stream. This is the merge side of the 4-way demux path.
- Round-robin arbitration between sources; a multi-beat packet holds the grant until its last beat.
- out_sel tags each output beat with its source index, so a downstream 4-way demux can route it back by the same 2-bit code.
- Sits between four Hack-word producers and a single shared consumer, e.g. a bus or memory port.

Parameters:
- WIDTH, 16, data width of each channel in bits (one Hack word).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  4*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_valid  input  4  per-channel beat valid.
- in_last  input  4  per-channel last beat of packet; single-beat packets hold it at 1.
- in_ready  output  4  per-channel accept; at most one bit set in any cycle.
- out_data  output  WIDTH  registered data of the selected beat.
- out_sel  output  2  source index of the beat on out_data (00=ch0 … 11=ch3).
- out_last  output  1  registered copy of the accepted beat's in_last.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, synchronous active-low (rst_n=0 sampled at clk edge):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - state=IDLE, ptr=3, so ch0 has top priority first.
  - in_ready=4'b0000 while rst_n=0.
- Load enable: load = ~out_valid | out_ready. The single output register accepts a new beat when it is empty or draining in the same cycle.
- Grant is combinational:
  - IDLE: scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the first channel with in_valid=1 is granted.
  - LOCKED: grant = lock_ch, regardless of its in_valid.
- in_ready[g] = load & granted(g); all other bits are 0. in_ready never depends on out_data.
- Transfer on channel g when in_valid[g] & in_ready[g]. At the next edge:
  - out_data = in_data[g]; out_sel = g; out_last = in_last[g]; out_valid = 1; ptr = g.
- Latency: 1 cycle from accepted input beat to out_valid. Full throughput of 1 beat/cycle while out_ready=1.
- If out_valid & out_ready and there is no transfer, out_valid=0 at the next edge.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_sel and out_last are stable.
- FSM:
  - IDLE → LOCKED (lock_ch=g) on a transfer with in_last[g]=0.
  - IDLE stays IDLE on a transfer with in_last[g]=1.
  - LOCKED → IDLE on a transfer from lock_ch with in_last=1.
  - LOCKED stays LOCKED while lock_ch is idle (in_valid low). Other channels wait; there is no timeout.
- Simultaneous requests: exactly one grant per cycle. Equal-rate requesters receive packets in rotation 0,1,2,3,0…
- Channel that drops in_valid with no transfer: the grant moves freely in IDLE; the protocol requires sources not to retract valid before a transfer.
- Reset mid-packet: the lock is discarded, the pending output beat is dropped (out_valid=0), and ptr=3.
- in_ready is never set for a channel other than lock_ch while LOCKED.

Decomposition:
- Shared package mux4way_pkg:
  - NUM_CH=4, SEL_W=2.
  - State enum {IDLE, LOCKED}.
  - Function for the channel slice offset.
- Sub-module rr_pick4: combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_valid, gnt_idx[1:0].
  - Reused by future 4-way arbiters.

Test Plan:
- Reset then single beat: rst_n=0 for 2 cycles, then in_valid=4'b0100, in_data ch2=16'h1234, in_last[2]=1, out_ready=1.
  → in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=16'h1234, out_sel=2'b10, out_last=1; following cycle out_valid=0.
- Round robin: all four valid with single-beat packets (data 16'hA000+i), out_ready=1 for 8 cycles.
  → out_sel sequence 0,1,2,3,0,1,2,3; one beat every cycle.
- Packet lock: ch1 sends 3 beats (last on the 3rd) while ch0 and ch3 are valid throughout.
  → out_sel=1,1,1 consecutively with out_last=0,0,1; then 3, then 0.
- Lock with gap: ch2 sends a non-last beat, then in_valid[2]=0 for 3 cycles while ch0 is valid.
  → in_ready[0]=0 throughout the gap; ch0 is served only after ch2's last beat.
- Backpressure: out_ready=0 for 4 cycles with an output beat pending.
  → out_data and out_sel stable, in_ready=4'b0000; the first cycle out_ready=1 accepts the next beat with no bubble.
- Reset mid-packet: assert rst_n=0 during a locked ch3 packet.
  → next cycle out_valid=0; after release, with ch0 and ch3 valid, ch0 is granted first.
